xbar_slave_arbiter: RTL
=======================

// Module: xbar_slave_arbiter
// PURPOSE
//  Shares one slave port among N_MASTERS master ports in the cross bar. Round-robin arbitration;
//  each grant is held for exactly one transaction, which ends on slave ack. Sits between the master
//  side and one slave of the master/slave bus (req/addr/cmd/wdata -> ack/rdata). One instance per slave.
// PARAMETERS
//  N_MASTERS   4    number of requesting masters (2..8)
//  ADDR_W      32   address width
//  DATA_W      32   data width
//  TIMEOUT     16   ack wait limit in cycles (used only with XBAR_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1              single clock, all logic on rising edge
//  rst          in   1              synchronous, active-high reset
//  m_s_req      in   N_MASTERS      per-master request
//  m_s_addr     in   N_MASTERS*ADDR_W   per-master address, slice i = master i
//  m_s_cmd      in   N_MASTERS      per-master command, 0=read 1=write
//  m_s_wdata    in   N_MASTERS*DATA_W   per-master write data
//  s_m_ack      out  N_MASTERS      per-master ack, one-cycle pulse
//  s_m_rdata    out  N_MASTERS*DATA_W   per-master read data, valid with ack
//  sl_req       out  1              request to slave
//  sl_addr      out  ADDR_W         address to slave
//  sl_cmd       out  1              command to slave
//  sl_wdata     out  DATA_W         write data to slave
//  sl_ack       in   1              slave ack, one-cycle pulse
//  sl_rdata     in   DATA_W         slave read data, valid with sl_ack
//  grant_id     out  $clog2(N_MASTERS)  index of current owner, valid in BUSY
// BEHAVIOUR
//  - Protocol: master holds req/addr/cmd/wdata stable until its ack. It drops req or starts a new
//    transaction the cycle after ack.
//  - FSM: IDLE, BUSY. IDLE: if |m_s_req, pick the first requester strictly after last_grant, wrapping
//    modulo N_MASTERS. Register grant_id, update last_grant, go to BUSY. BUSY: stay until sl_ack,
//    then go to IDLE.
//  - Outputs in BUSY: sl_req=1. sl_addr/sl_cmd/sl_wdata muxed from grant_id, combinational from the
//    master inputs.
//  - Outputs in IDLE: sl_req=0 and sl_addr/sl_cmd/sl_wdata=0.
//  - Latency: master req seen in cycle T -> sl_req in T+1 (no contention).
//  - sl_ack in cycle M -> s_m_ack[grant_id]=1 and s_m_rdata slice = sl_rdata in the same cycle M.
//  - One IDLE bubble cycle separates back-to-back transactions.
//  - Non-granted masters: ack=0, rdata slice=0. rdata slice is also 0 when no ack is present.
//  - sl_ack while IDLE: ignored, no master ack.
//  - Requests arriving in BUSY wait. A master dropping req mid-BUSY (protocol violation) does not
//    release the grant.
//  - Reset value of last_grant is N_MASTERS-1, so master 0 wins first.
//  - Reset values: state=IDLE, grant_id=0, sl_req=0, all s_m_ack=0, all rdata=0, sl_addr/cmd/wdata=0.
//  - Reset asserted mid-BUSY: next cycle IDLE, sl_req=0, the in-flight transaction is dropped, and
//    no ack is forwarded even if sl_ack coincides with rst.
// CONFIGURATION
//  XBAR_ARB_TIMEOUT_EN defined:
//   - Wait counter clears on entry to BUSY and counts BUSY cycles.
//   - If the counter reaches TIMEOUT without sl_ack: the granted master gets s_m_ack=1 with
//     rdata=32'hDEAD_BEEF for one cycle, the FSM goes to IDLE, and sl_req drops.
//   - A late sl_ack is later ignored (IDLE rule).
//   - sl_ack in the timeout cycle takes priority over the timeout.
//  XBAR_ARB_TIMEOUT_EN undefined: no counter, BUSY waits indefinitely. TIMEOUT is unused.
// STRUCTURE
//  - Package xbar_pkg: ADDR_W/DATA_W defaults, CMD_READ=1'b0 / CMD_WRITE=1'b1,
//    arb_state_t enum {ARB_IDLE, ARB_BUSY}, TIMEOUT_RDATA=32'hDEAD_BEEF.
//  - Sub-module rr_pick: combinational; inputs req vector and last_grant; outputs found and index.
//    Reused by the other crossbar slave ports.
// TESTING
//  1 Single master 2 write addr=0x100 wdata=0xA5A5_0001 -> sl_req next cycle, sl_cmd=1,
//    sl_addr=0x100; slave ack at +3 -> s_m_ack[2] same cycle.
//  2 Masters 0..3 all request together, repeating -> grant order 0,1,2,3,0; one bubble between each.
//  3 Read: slave returns 0x1234_5678 with ack -> only s_m_rdata[1] = 0x1234_5678; other slices
//    and acks are 0.
//  4 rst pulsed during BUSY with sl_ack same cycle -> no s_m_ack; sl_req=0 next cycle; then master 0
//    wins over master 3.
//  5 sl_ack injected while IDLE -> all s_m_ack stay 0; state stays IDLE.
//  6 (XBAR_ARB_TIMEOUT_EN, TIMEOUT=16) slave never acks -> after 16 BUSY cycles s_m_ack pulses with
//    0xDEAD_BEEF; next requester granted after a bubble.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared crossbar types and constants: bus widths, command encoding, arbiter state
// and the read data returned to a master whose slave never answered.
package xbar_pkg;

  localparam int XBAR_ADDR_W = 32;
  localparam int XBAR_DATA_W = 32;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted req strictly after last_grant, wrapping modulo N.
// Purely combinational; found is low when no request is pending.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic          found,
  output logic [IW-1:0] index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[IW'((int'(last_grant) + k) % N)]) begin
        found = 1'b1;
        index = IW'((int'(last_grant) + k) % N);
      end
    end
  end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// One slave port shared by N masters, round-robin, one transaction per grant; req->sl_req 1 cycle,
// ack passed through same cycle, one idle bubble between grants. XBAR_ARB_TIMEOUT_EN adds an ack timeout.
module xbar_slave_arbiter
  import xbar_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = XBAR_ADDR_W,
  parameter int DATA_W    = XBAR_DATA_W,
  parameter int TIMEOUT   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_s_req,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_s_addr,
  input  logic [N_MASTERS-1:0]          m_s_cmd,
  input  logic [N_MASTERS*DATA_W-1:0]   m_s_wdata,
  output logic [N_MASTERS-1:0]          s_m_ack,
  output logic [N_MASTERS*DATA_W-1:0]   s_m_rdata,
  output logic                          sl_req,
  output logic [ADDR_W-1:0]             sl_addr,
  output logic                          sl_cmd,
  output logic [DATA_W-1:0]             sl_wdata,
  input  logic                          sl_ack,
  input  logic [DATA_W-1:0]             sl_rdata,
  output logic [$clog2(N_MASTERS)-1:0]  grant_id
);

  localparam int IW = $clog2(N_MASTERS);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic          sl_req_q, sl_req_d;

  logic          busy;
  logic          timeout;
  logic          done;
  logic [DATA_W-1:0] done_rdata;
  logic          pick_found;
  logic [IW-1:0] pick_idx;

  logic [ADDR_W-1:0] addr_a  [N_MASTERS];
  logic [DATA_W-1:0] wdata_a [N_MASTERS];

  rr_pick #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_rr_pick (
    .req        (m_s_req),
    .last_grant (last_grant_q),
    .found      (pick_found),
    .index      (pick_idx)
  );

  assign busy = (state_q == ARB_BUSY);

`ifdef XBAR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Counter holds the number of BUSY cycles already elapsed; it fires in the TIMEOUT-th one.
  assign timeout = busy && !sl_ack && (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    wait_cnt_d = '0;
    if (busy) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Reset wins over a coinciding slave ack: the in-flight transaction is dropped silently.
  assign done       = busy && !rst && (sl_ack || timeout);
  assign done_rdata = sl_ack ? sl_rdata : DATA_W'(TIMEOUT_RDATA);

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d      = ARB_BUSY;
          grant_id_d   = pick_idx;
          last_grant_d = pick_idx;
        end
      end
      ARB_BUSY: begin
        if (sl_ack || timeout) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    sl_req_d = (state_d == ARB_BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= IW'(N_MASTERS - 1);
      sl_req_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      sl_req_q     <= sl_req_d;
    end
  end

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_master
    assign addr_a[i]  = m_s_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = m_s_wdata[i*DATA_W +: DATA_W];
    assign s_m_ack[i] = done && (grant_id_q == IW'(i));
    assign s_m_rdata[i*DATA_W +: DATA_W] = s_m_ack[i] ? done_rdata : '0;
  end

  assign sl_req   = sl_req_q;
  assign grant_id = grant_id_q;
  assign sl_addr  = busy ? addr_a[grant_id_q]  : '0;
  assign sl_cmd   = busy ? m_s_cmd[grant_id_q] : 1'b0;
  assign sl_wdata = busy ? wdata_a[grant_id_q] : '0;

endmodule
